dffram_port_arbiter: RTL and testbench

- Shares one single-port DFFRAM_RTL_2048 instance between the instruction-fetch port (I) and the load/store port (D) of the core.
- Arbitrates round-robin and drives the RAM's EN/WE/A/Di.
- Handles byte-lane alignment for byte, half and word stores.
- Extracts and sign-extends load data from the RAM's one-cycle registered Do and returns a tagged response to the winning requester.

---
 rtl/dffram_arb_pkg.sv | 38 +++
 rtl/dffram_lane_unit.sv | 49 ++++
 rtl/dffram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dffram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_arb_pkg.sv
// Shared encodings and helpers for the DFFRAM port arbiter.
// Access sizes, response owner and byte-lane helpers.
package dffram_arb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  function automatic logic [3:0] be_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_B:    be_mask = 4'b0001 << off;
      SZ_H:    be_mask = 4'b0011 << off;
      SZ_W:    be_mask = 4'b1111;
      default: be_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dffram_lane_unit.sv
// Byte-lane steering between the core and the 32-bit RAM word.
// Store replication/enables and load shift/extend, all combinational.
module dffram_lane_unit
  import dffram_arb_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_di,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_do,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sx;

  always_comb begin
    st_be = be_mask(st_size, st_off);
    st_di = st_wdata;
    case (st_size)
      SZ_B:    st_di = {4{st_wdata[7:0]}};
      SZ_H:    st_di = {2{st_wdata[15:0]}};
      default: ;
    endcase
  end

  assign shifted = ld_do >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    sx      = 1'b0;
    case (ld_size)
      SZ_B: begin
        sx      = shifted[7] & ~ld_unsigned;
        ld_data = {{24{sx}}, shifted[7:0]};
      end
      SZ_H: begin
        sx      = shifted[15] & ~ld_unsigned;
        ld_data = {{16{sx}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dffram_port_arbiter.sv
// Round-robin sharing of one single-port DFFRAM between fetch and LSU.
// Grants at issue, tagged response one cycle later from registered Do.
module dffram_port_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_req,
  input  logic [ADDRESS_LENGTH+1:0] i_addr,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [DATA_LENGTH-1:0]    i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [1:0]                d_size,
  input  logic                      d_unsigned,
  input  logic [ADDRESS_LENGTH+1:0] d_addr,
  input  logic [DATA_LENGTH-1:0]    d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_LENGTH-1:0]    d_rdata,
  output logic                      d_err,
  output logic                      ram_EN,
  output logic [3:0]                ram_WE,
  output logic [ADDRESS_LENGTH-1:0] ram_A,
  output logic [DATA_LENGTH-1:0]    ram_Di,
  input  logic [DATA_LENGTH-1:0]    ram_Do
);

  owner_e           pend_owner;
  logic             prio;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic             r_uns;
  logic             r_err;
  logic             r_we;

  logic [1:0]       d_off;
  logic             d_bad;
  logic             d_go;
  logic             d_win;
  logic             i_win;
  logic             contend;
  logic [3:0]       be;
  logic [31:0]      di;
  logic [31:0]      ld_data;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  assign d_off   = d_addr[1:0];
  assign d_bad   = (d_size == 2'b11) | misaligned(d_size, d_off);
  assign contend = i_req & d_req;

  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!RST) begin
      unique case (1'b1)
        contend: begin
          d_win = ~prio;
          i_win = prio;
        end
        d_req & ~i_req: d_win = 1'b1;
        i_req & ~d_req: i_win = 1'b1;
        default: ;
      endcase
    end
  end

  // Faulting D accesses are granted but never reach the RAM
  assign d_go   = d_win & ~d_bad;
  assign i_gnt  = i_win;
  assign d_gnt  = d_win;
  assign ram_EN = i_win | d_go;
  assign ram_WE = (d_go & d_we) ? be : 4'b0000;
  assign ram_Di = d_go ? di : '0;

  always_comb begin
    ram_A = '0;
    if (i_win)
      ram_A = i_addr[ADDRESS_LENGTH+1:2];
    else if (d_go)
      ram_A = d_addr[ADDRESS_LENGTH+1:2];
  end

  dffram_lane_unit u_lane (
    .st_size     (d_size),
    .st_off      (d_off),
    .st_wdata    (d_wdata),
    .st_be       (be),
    .st_di       (di),
    .ld_size     (r_size),
    .ld_off      (r_off),
    .ld_unsigned (r_uns),
    .ld_do       (ram_Do),
    .ld_data     (ld_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_owner <= OWN_NONE;
      prio       <= 1'b0;
      r_size     <= SZ_B;
      r_off      <= 2'b00;
      r_uns      <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      pend_owner <= i_win ? OWN_I :
                    d_win ? OWN_D : OWN_NONE;
      // Hand priority to whoever lost the contended grant
      if (contend)
        prio <= d_win;
      if (d_win) begin
        r_size <= d_size;
        r_off  <= d_off;
        r_uns  <= d_unsigned;
        r_err  <= d_bad;
        r_we   <= d_we;
      end
    end
  end

  assign i_rvalid = (pend_owner == OWN_I) & ~RST;
  assign d_rvalid = (pend_owner == OWN_D) & ~RST;
  assign i_rdata  = i_rvalid ? ram_Do : '0;
  assign d_err    = d_rvalid & r_err;
  assign d_rdata  = (d_rvalid & ~r_err & ~r_we) ? ld_data : '0;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Bench for the DFFRAM port arbiter: RAM model plus byte-level reference.
// Directed scenarios followed by constrained-random traffic.
module tb_dffram_port_arbiter;

  localparam int AL = 11;
  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_req;
  logic [AL+1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic          d_unsigned;
  logic [AL+1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          ram_EN;
  logic [3:0]    ram_WE;
  logic [AL-1:0] ram_A;
  logic [31:0]   ram_Di;
  logic [31:0]   ram_Do;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] ram [2048] = '{default: 32'h0};
  logic [31:0] ram_wr;
  logic [7:0]  ref_mem [8192];

  always #5 CLK = ~CLK;

  dffram_port_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .ram_EN     (ram_EN),
    .ram_WE     (ram_WE),
    .ram_A      (ram_A),
    .ram_Di     (ram_Di),
    .ram_Do     (ram_Do)
  );

  // Single-port RAM: byte-masked write, registered read, Do=0 when idle
  always_comb begin
    ram_wr = ram[ram_A];
    for (int b = 0; b < 4; b++)
      if (ram_WE[b]) ram_wr[8*b +: 8] = ram_Di[8*b +: 8];
  end

  always @(posedge CLK) begin
    if (ram_EN) begin
      ram[ram_A] <= ram_wr;
      ram_Do     <= ram_wr;
    end else begin
      ram_Do <= 32'h0;
    end
  end

  function automatic int nbytes(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic void ref_store(input int a, input int sz,
                                    input logic [31:0] v);
    for (int k = 0; k < nbytes(sz); k++)
      ref_mem[a + k] = v[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int sz,
                                           input bit uns);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(sz);
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = ref_mem[a + k];
    if (!uns && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic idle();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_size = B; d_unsigned = 0;
    d_addr = '0; d_wdata = '0;
  endtask

  task automatic set_d(input bit we, input logic [1:0] sz, input bit uns,
                       input int a, input logic [31:0] wd);
    d_req = 1; d_we = we; d_size = sz; d_unsigned = uns;
    d_addr = (AL+2)'(a); d_wdata = wd;
  endtask

  task automatic do_reset();
    @(negedge CLK); idle(); RST = 1;
    @(negedge CLK); RST = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1; i_req = 1; i_addr = 'h20; set_d(1, W, 0, 'h10, 32'h1234_5678);
    #1;
    n_run++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_i_gnt got %b want 0", i_gnt); end
    n_run++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
    n_run++; if (ram_EN !== 1'b0) begin n_fail++; $display("FAIL rst_en got %b want 0", ram_EN); end
    n_run++; if (ram_WE !== 4'h0) begin n_fail++; $display("FAIL rst_we got %h want 0", ram_WE); end
    @(negedge CLK);
    RST = 0; idle();
    #1;
    n_run++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_i_rvalid got %b want 0", i_rvalid); end
    n_run++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid got %b want 0", d_rvalid); end
    n_run++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL rst_d_err got %b want 0", d_err); end
    n_run++; if (i_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_i_rdata got %h want 0", i_rdata); end
    n_run++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got %h want 0", d_rdata); end
  endtask

  task automatic test_word();
    logic [31:0] exp;
    @(negedge CLK); idle(); set_d(1, W, 0, 'h10, 32'hDEAD_BEEF); #1;
    n_run++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL sw_gnt got %b want 1", d_gnt); end
    n_run++; if (ram_EN !== 1'b1) begin n_fail++; $display("FAIL sw_en got %b want 1", ram_EN); end
    n_run++; if (ram_WE !== 4'hF) begin n_fail++; $display("FAIL sw_we got %h want f", ram_WE); end
    n_run++; if (ram_A !== 11'd4) begin n_fail++; $display("FAIL sw_addr got %h want 4", ram_A); end
    n_run++; if (ram_Di !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_di got %h want deadbeef", ram_Di); end
    ref_store('h10, 2, 32'hDEAD_BEEF);
    @(negedge CLK); set_d(0, W, 0, 'h10, 0); #1;
    n_run++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL sw_rvalid got %b want 1", d_rvalid); end
    n_run++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h want 0", d_rdata); end
    n_run++; if (ram_WE !== 4'h0) begin n_fail++; $display("FAIL lw_we got %h want 0", ram_WE); end
    exp = ref_load('h10, 2, 0);
    @(negedge CLK); idle(); #1;
    n_run++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL lw_rvalid got %b want 1", d_rvalid); end
    n_run++; if (d_rdata !== exp) begin n_fail++; $display("FAIL lw_rdata got %h want %h", d_rdata, exp); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] e_lb, e_lbu, e_lw;
    @(negedge CLK); idle(); set_d(1, B, 0, 'h13, 32'h0000_0080); #1;
    n_run++; if (ram_WE !== 4'b1000) begin n_fail++; $display("FAIL sb_we got %b want 1000", ram_WE); end
    n_run++; if (ram_Di !== 32'h8080_8080) begin n_fail++; $display("FAIL sb_di got %h want 80808080", ram_Di); end
    ref_store('h13, 0, 32'h80);
    e_lb = ref_load('h13, 0, 0); e_lbu = ref_load('h13, 0, 1); e_lw = ref_load('h10, 2, 0);
    @(negedge CLK); set_d(0, B, 0, 'h13, 0); #1;
    @(negedge CLK); set_d(0, B, 1, 'h13, 0); #1;
    n_run++; if (d_rdata !== e_lb) begin n_fail++; $display("FAIL lb got %h want %h", d_rdata, e_lb); end
    @(negedge CLK); set_d(0, W, 0, 'h10, 0); #1;
    n_run++; if (d_rdata !== e_lbu) begin n_fail++; $display("FAIL lbu got %h want %h", d_rdata, e_lbu); end
    @(negedge CLK); idle(); #1;
    n_run++; if (d_rdata !== e_lw) begin n_fail++; $display("FAIL sb_neighbours got %h want %h", d_rdata, e_lw); end
  endtask

  task automatic test_alternation();
    bit exp_d, prev_d;
    logic [31:0] e_d, e_i;
    do_reset();
    i_req = 1; i_addr = 'h20; set_d(0, W, 0, 'h10, 0);
    e_d = ref_load('h10, 2, 0); e_i = ref_word('h20);
    exp_d = 1; prev_d = 0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 6) idle();
      #1;
      if (k < 6) begin
        n_run++; if (d_gnt !== exp_d) begin n_fail++; $display("FAIL alt_d_gnt[%0d] got %b want %b", k, d_gnt, exp_d); end
        n_run++; if (i_gnt !== !exp_d) begin n_fail++; $display("FAIL alt_i_gnt[%0d] got %b want %b", k, i_gnt, !exp_d); end
      end
      if (k > 0) begin
        n_run++; if (d_rvalid !== prev_d) begin n_fail++; $display("FAIL alt_d_rv[%0d] got %b want %b", k, d_rvalid, prev_d); end
        n_run++; if (i_rvalid !== !prev_d) begin n_fail++; $display("FAIL alt_i_rv[%0d] got %b want %b", k, i_rvalid, !prev_d); end
        if (prev_d) begin
          n_run++; if (d_rdata !== e_d) begin n_fail++; $display("FAIL alt_d_data[%0d] got %h want %h", k, d_rdata, e_d); end
        end else begin
          n_run++; if (i_rdata !== e_i) begin n_fail++; $display("FAIL alt_i_data[%0d] got %h want %h", k, i_rdata, e_i); end
        end
      end
      prev_d = exp_d;
      exp_d  = !exp_d;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp;
    @(negedge CLK); idle(); set_d(0, H, 0, 'h21, 0); #1;
    n_run++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL lh_mis_gnt got %b want 1", d_gnt); end
    n_run++; if (ram_EN !== 1'b0) begin n_fail++; $display("FAIL lh_mis_en got %b want 0", ram_EN); end
    @(negedge CLK); set_d(1, W, 0, 'h22, 32'h1234_5678); #1;
    n_run++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL lh_mis_err got %b want 1", d_err); end
    n_run++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL lh_mis_rdata got %h want 0", d_rdata); end
    n_run++; if (ram_WE !== 4'h0) begin n_fail++; $display("FAIL sw_mis_we got %h want 0", ram_WE); end
    @(negedge CLK); set_d(0, 2'b11, 0, 'h20, 0); #1;
    n_run++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL sw_mis_err got %b want 1", d_err); end
    n_run++; if (ram_EN !== 1'b0) begin n_fail++; $display("FAIL ill_en got %b want 0", ram_EN); end
    exp = ref_load('h20, 2, 0);
    @(negedge CLK); set_d(0, W, 0, 'h20, 0); #1;
    n_run++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL ill_err got %b want 1", d_err); end
    @(negedge CLK); idle(); #1;
    n_run++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL mis_lw_err got %b want 0", d_err); end
    n_run++; if (d_rdata !== exp) begin n_fail++; $display("FAIL mis_unmodified got %h want %h", d_rdata, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_lhu, e_lh;
    @(negedge CLK); idle(); set_d(1, H, 0, 'h22, 32'h0000_BEEF); #1;
    n_run++; if (ram_WE !== 4'b1100) begin n_fail++; $display("FAIL sh_we got %b want 1100", ram_WE); end
    ref_store('h22, 1, 32'hBEEF);
    e_lhu = ref_load('h22, 1, 1); e_lh = ref_load('h22, 1, 0);
    @(negedge CLK); set_d(0, H, 1, 'h22, 0); #1;
    n_run++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt got %b want 1", d_gnt); end
    @(negedge CLK); set_d(0, H, 0, 'h22, 0); #1;
    n_run++; if (d_rdata !== e_lhu) begin n_fail++; $display("FAIL b2b_lhu got %h want %h", d_rdata, e_lhu); end
    @(negedge CLK); idle(); #1;
    n_run++; if (d_rdata !== e_lh) begin n_fail++; $display("FAIL b2b_lh got %h want %h", d_rdata, e_lh); end
  endtask

  task automatic test_reset_drop();
    logic [31:0] exp;
    do_reset();
    i_req = 1; i_addr = 'h20; set_d(0, W, 0, 'h10, 0); #1;
    n_run++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_first_gnt got %b want 1", d_gnt); end
    @(negedge CLK); RST = 1; set_d(1, W, 0, 'h10, 32'h55AA_55AA); #1;
    n_run++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_rvalid got %b want 0", d_rvalid); end
    n_run++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_i_gnt got %b want 0", i_gnt); end
    n_run++; if (ram_WE !== 4'h0) begin n_fail++; $display("FAIL drop_we got %h want 0", ram_WE); end
    @(negedge CLK); RST = 0; set_d(0, W, 0, 'h10, 0); #1;
    n_run++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_post_rvalid got %b want 0", d_rvalid); end
    n_run++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_post_i_rvalid got %b want 0", i_rvalid); end
    n_run++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_prio_d got %b want 1", d_gnt); end
    exp = ref_load('h10, 2, 0);
    @(negedge CLK); idle(); #1;
    n_run++; if (d_rdata !== exp) begin n_fail++; $display("FAIL drop_no_write got %h want %h", d_rdata, exp); end
  endtask

  task automatic test_random();
    bit hold_i, hold_d, dw, iw, bad, en_e;
    int pend, m_prio, sz, a, off;
    logic [31:0] exp_rd;
    logic [3:0] we_e;
    bit exp_err;
    hold_i = 0; hold_d = 0; pend = 0; m_prio = 0;
    exp_rd = 0; exp_err = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge CLK);
      if (!hold_i) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = (AL+2)'($urandom_range(0, 127));
      end
      if (!hold_d) begin
        d_req      = ($urandom_range(0, 9) < 6);
        d_we       = 1'($urandom_range(0, 1));
        d_size     = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        d_unsigned = 1'($urandom_range(0, 1));
        d_addr     = (AL+2)'($urandom_range(0, 127));
        d_wdata    = $urandom;
      end
      #1;
      n_run++; if (i_rvalid !== (pend == 1)) begin n_fail++; $display("FAIL rnd_i_rv[%0d] got %b want %b", c, i_rvalid, pend == 1); end
      n_run++; if (d_rvalid !== (pend == 2)) begin n_fail++; $display("FAIL rnd_d_rv[%0d] got %b want %b", c, d_rvalid, pend == 2); end
      n_run++; if (d_err !== (pend == 2 && exp_err)) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", c, d_err, pend == 2 && exp_err); end
      n_run++; if (i_rdata !== ((pend == 1) ? exp_rd : 32'h0)) begin n_fail++; $display("FAIL rnd_i_data[%0d] got %h want %h", c, i_rdata, (pend == 1) ? exp_rd : 32'h0); end
      n_run++; if (d_rdata !== ((pend == 2) ? exp_rd : 32'h0)) begin n_fail++; $display("FAIL rnd_d_data[%0d] got %h want %h", c, d_rdata, (pend == 2) ? exp_rd : 32'h0); end
      dw = d_req && (!i_req || m_prio == 0);
      iw = i_req && !dw;
      n_run++; if (d_gnt !== dw) begin n_fail++; $display("FAIL rnd_d_gnt[%0d] got %b want %b", c, d_gnt, dw); end
      n_run++; if (i_gnt !== iw) begin n_fail++; $display("FAIL rnd_i_gnt[%0d] got %b want %b", c, i_gnt, iw); end
      sz  = int'(d_size);
      a   = int'(d_addr);
      off = a % 4;
      bad = (sz == 3) || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
      en_e = iw || (dw && !bad);
      we_e = 4'h0;
      if (dw && !bad && d_we)
        for (int k = 0; k < nbytes(sz); k++) we_e[off + k] = 1'b1;
      n_run++; if (ram_EN !== en_e) begin n_fail++; $display("FAIL rnd_en[%0d] got %b want %b", c, ram_EN, en_e); end
      n_run++; if (ram_WE !== we_e) begin n_fail++; $display("FAIL rnd_we[%0d] got %b want %b", c, ram_WE, we_e); end
      if (i_req && d_req) m_prio = dw ? 1 : 0;
      pend = 0;
      if (iw) begin
        pend   = 1;
        exp_rd = ref_word(int'(i_addr));
      end
      if (dw) begin
        pend    = 2;
        exp_err = bad;
        exp_rd  = (bad || d_we) ? 32'h0 : ref_load(a, sz, d_unsigned);
        if (!bad && d_we) ref_store(a, sz, d_wdata);
      end
      hold_i = i_req && !iw;
      hold_d = d_req && !dw;
    end
    @(negedge CLK); idle();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h0;
    RST = 1;
    idle();
    test_reset();
    test_word();
    test_byte_sign();
    test_alternation();
    test_misaligned();
    test_back_to_back();
    test_reset_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
